// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size encodings, FSM states and alignment check for the load/store unit
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      MERGE,
      WRITE,
      LATCH,
      DONE
   } lsu_state_t;

   // Illegal size code, odd halfword address, or word address not on a 4-byte boundary.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return off[0];
         SZ_WORD: return (off != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - combinational sub-word load extract/extend and store merge
import lsu_pkg::*;

module lsu_lane_align #(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [1:0]  off,
   input  logic [31:0] mem_word,
   input  logic [15:0] wdata_lo,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [1:0]  byte_lane;
   logic        half_lane;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Map the byte offset to a physical lane, then extract for loads and splice for stores.
   always_comb begin
      byte_lane  = BIG_ENDIAN ? ~off : off;
      half_lane  = BIG_ENDIAN ? ~off[1] : off[1];
      lane_b     = mem_word[{byte_lane, 3'b000} +: 8];
      lane_h     = mem_word[{half_lane, 4'b0000} +: 16];
      load_data  = mem_word;
      merge_data = mem_word;
      case (size)
         SZ_BYTE: begin
            load_data = {{24{sign_ext & lane_b[7]}}, lane_b};
            merge_data[{byte_lane, 3'b000} +: 8] = wdata_lo[7:0];
         end
         SZ_HALF: begin
            load_data = {{16{sign_ext & lane_h[15]}}, lane_h};
            merge_data[{half_lane, 4'b0000} +: 16] = wdata_lo;
         end
         default: begin
            load_data  = mem_word;
            merge_data = mem_word;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage FSM driving a word-wide syncram for byte/half/word access
import lsu_pkg::*;

module load_store_unit #(
   parameter int ADDR_W     = 32,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              done,
   output logic              stall,
   output logic              misalign,
   output logic              mem_cs,
   output logic              mem_oe,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_din,
   input  logic [31:0]       mem_dout
);

   lsu_state_t        state, state_nxt;
   logic              we_q, sext_q, accept;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q, load_data, merge_data;

   lsu_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
      .size       (size_q),
      .sign_ext   (sext_q),
      .off        (addr_q[1:0]),
      .mem_word   (mem_dout),
      .wdata_lo   (wdata_q[15:0]),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};

   // State register; reset drops straight back to IDLE so no pending write edge can fire.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and output decode from the current state and captured op.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      done      = 1'b0;
      stall     = 1'b0;
      misalign  = 1'b0;
      mem_cs    = 1'b0;
      mem_oe    = 1'b0;
      mem_we    = 1'b0;
      mem_din   = 32'h0;
      case (state)
         IDLE: begin
            if (req && reset) begin
               if (is_misaligned(size, addr[1:0])) begin
                  misalign = 1'b1;
               end else begin
                  accept    = 1'b1;
                  stall     = 1'b1;
                  state_nxt = (we && size == SZ_WORD) ? WRITE : READ;
               end
            end
         end
         READ: begin
            mem_cs    = 1'b1;
            mem_oe    = 1'b1;
            stall     = 1'b1;
            state_nxt = we_q ? MERGE : LATCH;
         end
         LATCH: begin
            stall     = 1'b1;
            state_nxt = DONE;
         end
         MERGE: begin
            mem_cs    = 1'b1;
            mem_we    = 1'b1;
            mem_din   = merge_data;
            stall     = 1'b1;
            state_nxt = DONE;
         end
         WRITE: begin
            mem_cs    = 1'b1;
            mem_we    = 1'b1;
            mem_din   = wdata_q;
            stall     = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Capture the op on accept; load result is registered on the LATCH exit edge only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_q    <= 1'b0;
         sext_q  <= 1'b0;
         size_q  <= SZ_BYTE;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         rdata   <= 32'h0;
      end else begin
         if (accept) begin
            we_q    <= we;
            sext_q  <= sign_ext;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= wdata;
         end
         if (state == LATCH) rdata <= load_data;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit against a behavioural memory model
import lsu_pkg::*;

module tb_load_store_unit;

   localparam bit BIG_ENDIAN = 1'b1;

   logic        clk = 1'b0;
   logic        reset, req, we, sign_ext;
   logic [1:0]  size;
   logic [31:0] addr, wdata, rdata, mem_addr, mem_din, mem_dout;
   logic        done, stall, misalign, mem_cs, mem_oe, mem_we;

   logic [31:0] mem     [0:63];
   logic [31:0] ref_mem [0:63];
   logic [31:0] last_rd;
   int          tests = 0;
   int          fails = 0;

   load_store_unit #(.ADDR_W(32), .BIG_ENDIAN(BIG_ENDIAN)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .we       (we),
      .size     (size),
      .sign_ext (sign_ext),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .done     (done),
      .stall    (stall),
      .misalign (misalign),
      .mem_cs   (mem_cs),
      .mem_oe   (mem_oe),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout)
   );

   always #5 clk = ~clk;

   // Syncram: write and read both happen on the edge that samples the controls.
   always @(posedge clk) begin
      if (mem_cs) begin
         if (mem_we) mem[mem_addr[7:2]] <= mem_din;
         if (mem_oe) mem_dout <= mem[mem_addr[7:2]];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int lane_shift(input logic [1:0] sz, input logic [1:0] off);
      int o;
      o = int'(off);
      if (sz == SZ_WORD) return 0;
      if (BIG_ENDIAN) return (sz == SZ_BYTE) ? (3 - o) * 8 : (2 - o) * 8;
      return o * 8;
   endfunction

   function automatic logic [31:0] size_mask(input logic [1:0] sz);
      if (sz == SZ_BYTE) return 32'h0000_00FF;
      if (sz == SZ_HALF) return 32'h0000_FFFF;
      return 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic se);
      logic [31:0] v, m;
      m = size_mask(sz);
      v = (ref_mem[a[7:2]] >> lane_shift(sz, a[1:0])) & m;
      if (se && sz == SZ_BYTE && v[7])  v = v | ~m;
      if (se && sz == SZ_HALF && v[15]) v = v | ~m;
      return v;
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] m;
      int          sh;
      m  = size_mask(sz);
      sh = lane_shift(sz, a[1:0]);
      ref_mem[a[7:2]] = (ref_mem[a[7:2]] & ~(m << sh)) | ((d & m) << sh);
   endtask

   // One legal op: request cycle, accept edge, then count cycles and memory strobes until done.
   task automatic do_op(input logic w, input logic [1:0] sz, input logic se,
                        input logic [31:0] a, input logic [31:0] d, input bit hold);
      int n, we_cyc, cs_cyc;
      @(posedge clk); #1;
      req = 1'b1; we = w; size = sz; sign_ext = se; addr = a; wdata = d;
      @(negedge clk);
      check("req_stall", stall, 1);
      check("req_misalign", misalign, 0);
      check("req_cs", mem_cs, 0);
      @(posedge clk); #1;
      if (!hold) begin
         req = 1'b0; we = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
      end
      n = 0; we_cyc = 0; cs_cyc = 0;
      do begin
         @(negedge clk);
         n++;
         if (!done) begin
            check("busy_stall", stall, 1);
            we_cyc += int'(mem_we);
            cs_cyc += int'(mem_cs);
         end
      end while (!done && n < 10);
      check("latency", n, (w && sz == SZ_WORD) ? 2 : 3);
      check("we_cycles", we_cyc, w ? 1 : 0);
      check("cs_cycles", cs_cyc, (w && sz != SZ_WORD) ? 2 : 1);
      check("done_stall", stall, 0);
      check("done_cs", mem_cs, 0);
      if (w) ref_store(a, sz, d);
      else   last_rd = ref_load(a, sz, se);
      check("rdata", rdata, last_rd);
   endtask

   task automatic try_misalign(input logic [1:0] sz, input logic [31:0] a);
      @(posedge clk); #1;
      req = 1'b1; we = 1'b0; size = sz; sign_ext = 1'b0; addr = a; wdata = $urandom;
      @(negedge clk);
      check("mis_flag", misalign, 1);
      check("mis_cs", mem_cs, 0);
      check("mis_stall", stall, 0);
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      check("mis_idle_cs", mem_cs, 0);
      check("mis_idle_done", done, 0);
      check("mis_mem", mem[a[7:2]], ref_mem[a[7:2]]);
   endtask

   initial begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          done_seen;
      reset = 1'b0; req = 1'b0; we = 1'b0; size = SZ_WORD; sign_ext = 1'b0;
      addr = 32'h0; wdata = 32'h0; last_rd = 32'h0;
      for (int i = 0; i < 64; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      repeat (3) @(negedge clk);
      check("rst_rdata", rdata, 0);
      check("rst_ctrl", {done, stall, misalign, mem_cs, mem_oe, mem_we}, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_din", mem_din, 0);
      reset = 1'b1;

      do_op(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
      do_op(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0);
      check("lw_deadbeef", rdata, 32'hDEAD_BEEF);

      do_op(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h12F4_5678, 1'b0);
      do_op(1'b0, SZ_BYTE, 1'b1, 32'h21, 32'h0, 1'b0);
      check("lb_21", rdata, 32'hFFFF_FFF4);
      do_op(1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0, 1'b0);
      check("lbu_21", rdata, 32'h0000_00F4);
      do_op(1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, 1'b0);
      check("lh_22", rdata, 32'h0000_5678);

      do_op(1'b1, SZ_WORD, 1'b0, 32'h30, 32'h1122_3344, 1'b0);
      do_op(1'b1, SZ_HALF, 1'b0, 32'h32, 32'h0000_ABCD, 1'b0);
      check("sh_mem", mem[12], 32'h1122_ABCD);
      do_op(1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 1'b0);
      check("sh_readback", rdata, 32'h1122_ABCD);

      try_misalign(SZ_WORD, 32'h13);
      try_misalign(2'b11, 32'h40);

      do_op(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1);
      do_op(1'b0, SZ_HALF, 1'b0, 32'h20, 32'h0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         sz = 2'($urandom_range(0, 2));
         a  = 32'($urandom_range(0, 63)) * 4;
         if (sz == SZ_BYTE) a = a + 32'($urandom_range(0, 3));
         if (sz == SZ_HALF) a = a + 32'($urandom_range(0, 1)) * 2;
         do_op(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b0);
      end
      for (int i = 0; i < 64; i++) check("mem_final", mem[i], ref_mem[i]);

      do_op(1'b1, SZ_WORD, 1'b0, 32'h50, 32'h0, 1'b0);
      @(posedge clk); #1;
      req = 1'b1; we = 1'b1; size = SZ_BYTE; sign_ext = 1'b0; addr = 32'h50; wdata = 32'hFF;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      check("merge_we", mem_we, 1);
      reset = 1'b0;
      #1;
      check("abort_we", mem_we, 0);
      check("abort_cs", mem_cs, 0);
      check("abort_stall", stall, 0);
      check("abort_done", done, 0);
      check("abort_rdata", rdata, 0);
      @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      last_rd = 32'h0;
      done_seen = 0;
      repeat (4) begin
         @(negedge clk);
         done_seen += int'(done);
      end
      check("abort_no_done", done_seen, 0);
      check("abort_mem", mem[20], 32'h0);
      do_op(1'b0, SZ_WORD, 1'b0, 32'h50, 32'h0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-stage block between the datapath's ALU result / read_data_2 and the word-wide gac_syncram data memory. Executes word, halfword and byte loads and stores. Sub-word stores use read-modify-write. Sub-word loads are aligned, and sign- or zero-extended. Asserts stall so the PC register holds while a multi-cycle access is in flight; rdata feeds the mem_to_reg mux.

Parameters:
ADDR_W, 32, byte-address width of addr and mem_addr.
BIG_ENDIAN, 1, 1: byte offset 0 = bits 31:24 (MIPS); 0: byte offset 0 = bits 7:0.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset (clock is clk, reset is reset; polarity and asynchronous behaviour are fixed).
req  in  1  memory op request from control (MemRead|MemWrite).
we  in  1  1 = store, 0 = load.
size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
sign_ext  in  1  loads only: 1 = lb/lh, 0 = lbu/lhu.
addr  in  ADDR_W  byte address (ALU result).
wdata  in  32  store data, right-justified.
rdata  out  32  load result, registered.
done  out  1  one-cycle completion pulse.
stall  out  1  hold PC / suppress register write.
misalign  out  1  illegal size or misaligned address; no access performed.
mem_cs, mem_oe, mem_we  out  1 each  syncram controls.
mem_addr  out  ADDR_W  word address {addr[ADDR_W-1:2], 2'b00}.
mem_din  out  32  syncram write data.
mem_dout  in  32  syncram read data; valid the cycle after the edge that samples mem_oe.

Behaviour:
- Reset: state = IDLE. rdata = 0. done, stall, misalign, mem_cs, mem_oe and mem_we = 0. mem_addr and mem_din = 0.
- States: IDLE, READ, MERGE, WRITE, LATCH, DONE. Memory controls are decoded combinationally from state and the captured op registers.
- Accept: in IDLE with req=1 and a legal, aligned op, capture we/size/sign_ext/addr/wdata at edge E0.
  - Load or sub-word store: go to READ.
  - Word store: go to WRITE.
- Misalign conditions: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=0.
  - On misalign: misalign=1 combinationally in that IDLE cycle. State stays IDLE, no memory control asserted, stall=0.
- READ: mem_cs=1, mem_oe=1. Next state is LATCH (load) or MERGE (store).
- LATCH: extract the lane from mem_dout. Zero- or sign-extend per size/sign_ext. Register into rdata at the exit edge, then go to DONE.
- MERGE: mem_cs=1, mem_we=1. mem_din = mem_dout with only the addressed byte/half lane replaced by wdata[7:0] or wdata[15:0]. Go to DONE.
- WRITE: mem_cs=1, mem_we=1, mem_din=wdata. Go to DONE.
- DONE: done=1, stall=0. req is ignored (it belongs to the completing instruction). Always return to IDLE.
- stall = (IDLE & req & legal) | state in {READ, LATCH, MERGE, WRITE}. The PC therefore never advances on the accept edge.
- Latency from accept edge E0 to done:
  - Load: done high in cycle E2–E3; rdata valid from E2 and held until the next load completes.
  - Word store: done in cycle E1–E2.
  - Sub-word store: done in cycle E2–E3; exactly one mem_we cycle.
- Lane select: byte offset addr[1:0], half offset addr[1], mapped per BIG_ENDIAN.
- Stores never modify rdata.
- Inputs are don't-care after the accept edge.
- Reset asserted mid-operation: immediately return to IDLE and clear all outputs, including mem_we.
  - A write whose edge has not occurred is not performed.
  - No done pulse is issued for the aborted op.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state enum lsu_state_t;
  - misalign check function.
- Sub-module lsu_lane_align: purely combinational. Performs load extract/extend and store merge, parameterised by BIG_ENDIAN. The top level holds the FSM and registers.

Test Plan:
- sw 0xDEADBEEF @0x10, then lw @0x10 -> rdata=0xDEADBEEF. Store done 2 cycles after accept; load done 3 cycles after accept; stall high from the request cycle through the last non-DONE cycle.
- Memory word 0x12F45678 @0x20, BIG_ENDIAN=1: lb @0x21 -> rdata=0xFFFFFFF4; lbu @0x21 -> 0x000000F4; lh @0x22 -> 0x00005678.
- sh wdata=0x0000ABCD @0x32 over word 0x11223344 -> memory word 0x1122ABCD. mem_we high exactly one cycle (MERGE); lw readback matches.
- lw @0x13 and size=11 @0x40 -> misalign=1 in the same cycle; mem_cs=0, stall=0, state stays IDLE; memory untouched.
- reset low during MERGE of sb 0xFF @0x50 over 0x00000000 -> mem_we drops asynchronously; state IDLE; rdata=0; no done; word still 0x00000000.
- req held high through DONE -> no second access. A new req in the following IDLE cycle is accepted normally.
